// File: rtl/sweep_sequencer_pkg.sv
// Shared types and constants for the solar tracker sweep scheduler.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package sweep_sequencer_pkg;

    localparam int POS_W = 32;

    // Direction codes shared with servo_driver (btn1 = CW, btn0 = CCW).
    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_CCW  = 2'b01;
    localparam logic [1:0] DIR_CW   = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        H_HOME   = 3'd1,
        H_SWEEP  = 3'd2,
        H_RETURN = 3'd3,
        V_HOME   = 3'd4,
        V_SWEEP  = 3'd5,
        V_RETURN = 3'd6,
        DONE     = 3'd7
    } state_t;

    // States in which a servo is being commanded and the phase timeout applies.
    function automatic logic is_motion(input state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

    function automatic logic is_h_phase(input state_t s);
        return (s == H_HOME) || (s == H_SWEEP) || (s == H_RETURN);
    endfunction

    function automatic logic is_v_phase(input state_t s);
        return (s == V_HOME) || (s == V_SWEEP) || (s == V_RETURN);
    endfunction

    // Horizontal servo direction requested while in state s.
    function automatic logic [1:0] h_dir_of(input state_t s);
        logic [1:0] d;
        d = DIR_STOP;
        case (s)
            H_HOME, H_RETURN: d = DIR_CCW;
            H_SWEEP:          d = DIR_CW;
            default:          d = DIR_STOP;
        endcase
        return d;
    endfunction

    // Vertical servo direction requested while in state s.
    function automatic logic [1:0] v_dir_of(input state_t s);
        logic [1:0] d;
        d = DIR_STOP;
        case (s)
            V_HOME, V_RETURN: d = DIR_CCW;
            V_SWEEP:          d = DIR_CW;
            default:          d = DIR_STOP;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sweep_sequencer_peak_tracker.sv
// Running-maximum tracker: keeps the largest light sample and the position it was seen at.
// Latency: best_val/best_pos update on the edge that samples valid/clear; best_pos_nxt is the combinational next value.
// Backpressure: none; every valid sample is consumed in its cycle.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   clear             load best_val = 0, best_pos = position (wins over valid)
//   valid, data       light sample strobe and value
//   position          position paired with the sample
//   best_val/best_pos registered peak and its position
//   best_pos_nxt      value best_pos takes at the next edge
module sweep_sequencer_peak_tracker
    import sweep_sequencer_pkg::*;
#(
    parameter int LIGHT_W = 12
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               clear,
    input  logic               valid,
    input  logic [LIGHT_W-1:0] data,
    input  logic [POS_W-1:0]   position,
    output logic [LIGHT_W-1:0] best_val,
    output logic [POS_W-1:0]   best_pos,
    output logic [POS_W-1:0]   best_pos_nxt
);

    logic [LIGHT_W-1:0] best_val_nxt;
    logic               hit;

    // Strictly greater: on a tie the earlier position is kept.
    assign hit = valid && (data > best_val);

    always_comb begin
        best_val_nxt = best_val;
        best_pos_nxt = best_pos;
        if (clear) begin
            best_val_nxt = '0;
            best_pos_nxt = position;
        end else if (hit) begin
            best_val_nxt = data;
            best_pos_nxt = position;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            best_val <= '0;
            best_pos <= '0;
        end else begin
            best_val <= best_val_nxt;
            best_pos <= best_pos_nxt;
        end
    end

endmodule

// File: rtl/sweep_sequencer.sv
// Sweep scheduler: home -> sweep -> return for H then V, tracking the brightest position of each axis.
// Latency: all outputs registered from next-state decode; one cycle from exit condition to new state/outputs.
// Backpressure: none; START ignored while busy, ABORT always wins and releases all motion.
//
// Ports:
//   CLK, RST                       100 MHz clock, asynchronous active-high reset
//   START, ABORT                   scan request (IDLE only) / immediate return to IDLE
//   light_valid, light_data        light sample strobe and value
//   h_/v_position, h_/v_limit      axis PWM high time and limit flag
//   h_/v_btn0, h_/v_btn1, h_/v_es  CCW request, CW request, axis enable
//   busy, done, timeout_err        not-IDLE, completion pulse, sticky phase timeout
//   h_best, v_best, best_light     captured best positions and last axis peak light
module sweep_sequencer
    import sweep_sequencer_pkg::*;
#(
    parameter logic [POS_W-1:0] POS_MIN     = 32'd5000,
    parameter logic [POS_W-1:0] POS_MAX     = 32'd25000,
    parameter int               LIGHT_W     = 12,
    parameter logic [POS_W-1:0] TIMEOUT_CYC = 32'd200_000_000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               ABORT,
    input  logic               light_valid,
    input  logic [LIGHT_W-1:0] light_data,
    input  logic [POS_W-1:0]   h_position,
    input  logic [POS_W-1:0]   v_position,
    input  logic               h_limit,
    input  logic               v_limit,
    output logic               h_btn0,
    output logic               h_btn1,
    output logic               v_btn0,
    output logic               v_btn1,
    output logic               h_es,
    output logic               v_es,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [POS_W-1:0]   h_best,
    output logic [POS_W-1:0]   v_best,
    output logic [LIGHT_W-1:0] best_light
);

    // The phase ends on the edge where the counter has already counted
    // TIMEOUT_CYC-1, so a stuck phase occupies exactly TIMEOUT_CYC cycles.
    localparam logic [POS_W-1:0] CNT_LAST = TIMEOUT_CYC - 32'd1;

    state_t           state;
    state_t           next_state;
    logic [POS_W-1:0] phase_cnt;
    logic             timeout_hit;

    logic             trk_clear;
    logic             trk_valid;
    logic [POS_W-1:0] trk_pos_in;
    logic [POS_W-1:0] trk_best_pos;
    logic [POS_W-1:0] trk_best_pos_nxt;
    logic             h_load;
    logic             v_load;
    logic [1:0]       h_dir_nxt;
    logic [1:0]       v_dir_nxt;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;

        case (state)
            IDLE:     if (START)                                next_state = H_HOME;
            H_HOME:   if (h_position <= POS_MIN)                next_state = H_SWEEP;
            H_SWEEP:  if (h_limit || (h_position >= POS_MAX))   next_state = H_RETURN;
            // The tracker still holds the H result here, so its position is h_best.
            H_RETURN: if (h_position <= trk_best_pos)           next_state = V_HOME;
            V_HOME:   if (v_position <= POS_MIN)                next_state = V_SWEEP;
            V_SWEEP:  if (v_limit || (v_position >= POS_MAX))   next_state = V_RETURN;
            V_RETURN: if (v_position <= trk_best_pos)           next_state = DONE;
            DONE:                                               next_state = IDLE;
            default:                                            next_state = IDLE;
        endcase

        // A normal exit taken on the same edge beats the timeout.
        if (is_motion(state) && (next_state == state) && (phase_cnt >= CNT_LAST)) begin
            next_state  = IDLE;
            timeout_hit = 1'b1;
        end

        if (ABORT) begin
            next_state  = IDLE;
            timeout_hit = 1'b0;
        end
    end

    assign h_dir_nxt = h_dir_of(next_state);
    assign v_dir_nxt = v_dir_of(next_state);

    // ------------------------------------------------------------------
    // Peak tracking, shared between axes
    // ------------------------------------------------------------------
    assign trk_clear  = ((next_state == H_SWEEP) && (state != H_SWEEP)) ||
                        ((next_state == V_SWEEP) && (state != V_SWEEP));
    // Sampling is keyed on the current state, so a sample arriving on the
    // sweep's exit edge is still taken.
    assign trk_valid  = light_valid && ((state == H_SWEEP) || (state == V_SWEEP));
    assign trk_pos_in = is_h_phase(state) ? h_position : v_position;

    // Axis best registers follow the tracker's next value while that axis sweeps,
    // so they are current on the first cycle of the RETURN phase.
    assign h_load = is_h_phase(state) && (trk_clear || (state == H_SWEEP));
    assign v_load = is_v_phase(state) && (trk_clear || (state == V_SWEEP));

    sweep_sequencer_peak_tracker #(
        .LIGHT_W (LIGHT_W)
    ) peak_tracker (
        .CLK          (CLK),
        .RST          (RST),
        .clear        (trk_clear),
        .valid        (trk_valid),
        .data         (light_data),
        .position     (trk_pos_in),
        .best_val     (best_light),
        .best_pos     (trk_best_pos),
        .best_pos_nxt (trk_best_pos_nxt)
    );

    // ------------------------------------------------------------------
    // State, counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            phase_cnt   <= '0;
            h_btn0      <= 1'b0;
            h_btn1      <= 1'b0;
            v_btn0      <= 1'b0;
            v_btn1      <= 1'b0;
            h_es        <= 1'b0;
            v_es        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            h_best      <= '0;
            v_best      <= '0;
        end else begin
            state <= next_state;

            if (next_state != state) begin
                phase_cnt <= '0;
            end else if (phase_cnt != '1) begin
                phase_cnt <= phase_cnt + 32'd1;
            end

            h_btn0 <= (h_dir_nxt == DIR_CCW);
            h_btn1 <= (h_dir_nxt == DIR_CW);
            v_btn0 <= (v_dir_nxt == DIR_CCW);
            v_btn1 <= (v_dir_nxt == DIR_CW);
            h_es   <= is_h_phase(next_state);
            v_es   <= is_v_phase(next_state);
            busy   <= (next_state != IDLE);
            done   <= (next_state == DONE);

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if ((state == IDLE) && START && !ABORT) begin
                timeout_err <= 1'b0;
            end

            if (h_load) begin
                h_best <= trk_best_pos_nxt;
            end
            if (v_load) begin
                v_best <= trk_best_pos_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer with a simple +/-10 per cycle servo model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sweep_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic        light_valid = 1'b0;
    logic [11:0] light_data = '0;
    logic [31:0] h_position = 32'd12000;
    logic [31:0] v_position = 32'd12000;
    logic        h_limit = 1'b0;
    logic        v_limit = 1'b0;

    logic        h_btn0, h_btn1, v_btn0, v_btn1, h_es, v_es;
    logic        busy, done, timeout_err;
    logic [31:0] h_best, v_best;
    logic [11:0] best_light;

    // Second instance with a short timeout and a frozen servo.
    logic        start2 = 1'b0;
    logic        abort2 = 1'b0;
    logic        b2_h_btn0, b2_h_btn1, b2_v_btn0, b2_v_btn1, b2_h_es, b2_v_es;
    logic        b2_busy, b2_done, b2_to;
    logic [31:0] b2_h_best, b2_v_best;
    logic [11:0] b2_best_light;

    int          compared = 0;
    int          mismatched = 0;
    int          light_mode = 0;
    logic [31:0] limit_at = 32'hFFFF_FFFF;

    always #5 CLK = ~CLK;

    sweep_sequencer #(
        .POS_MIN(32'd5000), .POS_MAX(32'd25000), .LIGHT_W(12), .TIMEOUT_CYC(32'd5000)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .light_valid(light_valid), .light_data(light_data),
        .h_position(h_position), .v_position(v_position),
        .h_limit(h_limit), .v_limit(v_limit),
        .h_btn0(h_btn0), .h_btn1(h_btn1), .v_btn0(v_btn0), .v_btn1(v_btn1),
        .h_es(h_es), .v_es(v_es), .busy(busy), .done(done), .timeout_err(timeout_err),
        .h_best(h_best), .v_best(v_best), .best_light(best_light)
    );

    sweep_sequencer #(
        .POS_MIN(32'd5000), .POS_MAX(32'd25000), .LIGHT_W(12), .TIMEOUT_CYC(32'd100)
    ) dut_to (
        .CLK(CLK), .RST(RST), .START(start2), .ABORT(abort2),
        .light_valid(1'b0), .light_data(12'd0),
        .h_position(32'd12000), .v_position(32'd12000),
        .h_limit(1'b0), .v_limit(1'b0),
        .h_btn0(b2_h_btn0), .h_btn1(b2_h_btn1), .v_btn0(b2_v_btn0), .v_btn1(b2_v_btn1),
        .h_es(b2_h_es), .v_es(b2_v_es), .busy(b2_busy), .done(b2_done), .timeout_err(b2_to),
        .h_best(b2_h_best), .v_best(b2_v_best), .best_light(b2_best_light)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Light depends on the position of whichever axis is enabled.
    task automatic update_inputs();
        logic [31:0] p, pk, d, l;
        if (v_es) begin p = v_position; pk = 32'd9000;  end
        else      begin p = h_position; pk = 32'd15000; end
        case (light_mode)
            0: begin
                d = (p > pk) ? (p - pk) : (pk - p);
                l = 32'd4000 - d / 32'd10;
            end
            1:       l = ((p == 32'd11000) || (p == 32'd18000)) ? 32'd800 : 32'd100;
            default: l = p / 32'd10;
        endcase
        light_data = l[11:0];
        h_limit    = (h_position >= limit_at);
    endtask

    // One clock: sample point is 1 time unit after the edge; servo model moves there.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (h_btn1)      h_position = h_position + 32'd10;
        else if (h_btn0) h_position = h_position - 32'd10;
        if (v_btn1)      v_position = v_position + 32'd10;
        else if (v_btn0) v_position = v_position - 32'd10;
        update_inputs();
    endtask

    initial begin
        int  done_cnt;
        int  both_cnt;
        int  dn;
        bit  seen_sweep;

        // ---------------- reset ----------------
        light_valid = 1'b1;
        update_inputs();
        #2 RST = 1'b1;
        tick();
        tick();
        chk("rst_busy",   busy, 0);
        chk("rst_h_btn0", h_btn0, 0);
        chk("rst_done",   done, 0);
        chk("rst_to",     timeout_err, 0);
        chk("rst_h_best", h_best, 0);
        chk("rst_light",  best_light, 0);
        RST = 1'b0;
        tick();

        // ---------------- full scan ----------------
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("start_busy",  busy, 1);
        chk("start_hbtn0", h_btn0, 1);
        chk("start_hbtn1", h_btn1, 0);
        chk("start_h_es",  h_es, 1);
        chk("start_v_es",  v_es, 0);
        done_cnt   = 0;
        both_cnt   = 0;
        seen_sweep = 1'b0;
        for (int i = 0; i < 12000 && busy; i++) begin
            tick();
            if ((h_btn0 && h_btn1) || (v_btn0 && v_btn1)) both_cnt++;
            if (done) done_cnt++;
            if (h_btn1 && !seen_sweep) begin
                seen_sweep = 1'b1;
                chk("hsweep_entry_best",  h_best, 5000);
                chk("hsweep_entry_light", best_light, 0);
            end
        end
        chk("scan_idle",     busy, 0);
        chk("scan_done_cnt", done_cnt, 1);
        chk("scan_both_btn", both_cnt, 0);
        chk("scan_h_best",   h_best, 15000);
        chk("scan_v_best",   v_best, 9000);
        chk("scan_light",    best_light, 4000);
        chk("scan_h_pos",    h_position, 15000);
        chk("scan_v_pos",    v_position, 9000);
        chk("scan_to",       timeout_err, 0);

        // ---------------- already home, then ties ----------------
        light_mode = 1;
        h_position = 32'd4000;
        update_inputs();
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("home_hbtn0", h_btn0, 1);
        tick();
        chk("home_1cyc_hbtn1", h_btn1, 1);
        chk("home_1cyc_hbtn0", h_btn0, 0);
        chk("home_entry_best", h_best, 3990);
        chk("home_entry_light", best_light, 0);
        for (int i = 0; i < 3000 && h_btn1; i++) tick();
        chk("ties_return",   h_btn0, 1);
        chk("ties_h_best",   h_best, 11000);
        chk("ties_light",    best_light, 800);

        // ---------------- ABORT mid-H_RETURN ----------------
        repeat (50) tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_busy",  busy, 0);
        chk("abort_hbtn0", h_btn0, 0);
        chk("abort_h_es",  h_es, 0);
        chk("abort_done",  done, 0);
        dn = 0;
        repeat (5) begin
            tick();
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_idle",    busy, 0);

        // ---------------- limit flag ends sweep ----------------
        light_mode = 2;
        limit_at   = 32'd20000;
        h_position = 32'd5000;
        update_inputs();
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        chk("lim_sweep",      h_btn1, 1);
        chk("lim_entry_best", h_best, 4990);
        for (int i = 0; i < 3000 && h_btn1; i++) tick();
        chk("lim_return",   h_btn0, 1);
        chk("lim_h_best",   h_best, 20000);
        chk("lim_light",    best_light, 2000);
        tick();
        chk("lim_v_home",   v_btn0, 1);
        chk("lim_h_es",     h_es, 0);
        chk("lim_v_es",     v_es, 1);
        chk("lim_hbtn0",    h_btn0, 0);

        // ---------------- RST mid-V_SWEEP ----------------
        for (int i = 0; i < 2000 && !v_btn1; i++) tick();
        repeat (20) tick();
        chk("vsweep_active", v_btn1, 1);
        #3;
        RST = 1'b1;
        #1;
        chk("arst_busy",   busy, 0);
        chk("arst_vbtn1",  v_btn1, 0);
        chk("arst_v_es",   v_es, 0);
        chk("arst_h_best", h_best, 0);
        chk("arst_v_best", v_best, 0);
        chk("arst_light",  best_light, 0);
        tick();
        RST = 1'b0;
        limit_at = 32'hFFFF_FFFF;
        tick();

        // ---------------- stalled servo timeout ----------------
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("to_start_busy",  b2_busy, 1);
        chk("to_start_hbtn0", b2_h_btn0, 1);
        repeat (99) tick();
        chk("to_99_busy", b2_busy, 1);
        chk("to_99_err",  b2_to, 0);
        tick();
        chk("to_100_busy",  b2_busy, 0);
        chk("to_100_err",   b2_to, 1);
        chk("to_100_hbtn0", b2_h_btn0, 0);
        chk("to_100_h_es",  b2_h_es, 0);
        tick();
        chk("to_sticky", b2_to, 1);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("to_clear_err",  b2_to, 0);
        chk("to_clear_busy", b2_busy, 1);
        abort2 = 1'b1;
        tick();
        abort2 = 1'b0;
        chk("to_abort_busy", b2_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sweep_sequencer.md
# sweep_sequencer

Top-level sweep scheduler for the solar tracker. Sequences the horizontal and vertical servo drivers through home → sweep → return phases. Drives their BTN_0/BTN_1 direction requests and ES enables, and samples the light sensor during each sweep to locate the brightest position. It sits between the user/start logic and the two servo driver instances, and owns the only path that commands servo motion in automatic mode.

## Interface
Parameters:
- POS_MIN, 32'd5000: home position in PWM high-time units; homing stops at `position <= POS_MIN`.
- POS_MAX, 32'd25000: sweep end position; sweep also stops on the axis limit flag.
- LIGHT_W, 12: light sample width.
- TIMEOUT_CYC, 32'd200_000_000: maximum cycles per phase before abort.

Ports:
- CLK  in  1: system clock, 100 MHz.
- RST  in  1: asynchronous, active-high reset.
- START  in  1: one-cycle request to begin a full H-then-V scan; ignored unless IDLE.
- ABORT  in  1: return to IDLE at the next edge; all motion is released.
- light_valid  in  1: one-cycle strobe qualifying light_data.
- light_data  in  LIGHT_W: photodiode/ADC sample.
- h_position, v_position  in  32: current PWM high time of each axis.
- h_limit, v_limit  in  1: PWM limit flag of each axis.
- h_btn0, h_btn1, v_btn0, v_btn1  out  1: direction requests; btn0 = CCW (position decreasing), btn1 = CW (position increasing); never both high.
- h_es, v_es  out  1: sweep enable; high for the whole of that axis's phases.
- busy  out  1: high in any state other than IDLE.
- done  out  1: one-cycle pulse on normal completion.
- timeout_err  out  1: sticky flag; cleared by START or RST.
- h_best, v_best  out  32: captured best position per axis.
- best_light  out  LIGHT_W: peak light of the most recently swept axis.

## Operation
- States and transitions:
  - IDLE: START → H_HOME.
  - H_HOME: h_btn0 high until `h_position <= POS_MIN`, then → H_SWEEP.
  - H_SWEEP: h_btn1 high until `h_limit` or `h_position >= POS_MAX`, then → H_RETURN.
  - H_RETURN: h_btn0 high until `h_position <= h_best`, then → V_HOME.
  - V_HOME, V_SWEEP, V_RETURN: identical to the H phases, using the v_ signals.
  - V_RETURN exit → DONE.
  - DONE: → IDLE after one cycle; done pulses during this cycle.
- Peak capture, in SWEEP states only:
  - On entry to SWEEP, clear best_light to 0 and set the axis best to the current position.
  - On light_valid, if `light_data > best_light` (strict), update best_light and capture the axis position at that sample. Ties keep the earlier position.
- A light_valid that arrives in the same cycle as the sweep exit condition is still captured. H_RETURN/V_RETURN then compare against the updated best.
- If a phase's exit condition is already true on entry, the state leaves after one cycle, for example when the servo is already home.
- Phase counter:
  - Reset to 0 on every state change; increments otherwise.
  - When it reaches TIMEOUT_CYC in any motion state: → IDLE, timeout_err set, all btn/es low.
- ABORT has priority over every other transition. START in a non-IDLE state is ignored. ABORT and START in the same cycle in IDLE: stay IDLE.
- Position comparisons are unsigned 32-bit. The counter saturates and does not wrap.

## Timing
- Reset values: state IDLE, all btn/es/busy/done/timeout_err low, h_best/v_best/best_light = 0, counter 0.
- All outputs are registered from next-state decode, so they are valid in the first cycle of the new state:
  - START sampled at edge N → busy and h_btn0 high after edge N.
- Exit conditions are sampled each edge. The btn request drops on the same edge the state leaves, so there is one cycle of decision latency.
- Between HOME→SWEEP and SWEEP→RETURN the direction flips directly, with no stop cycle. servo_driver registers direction, so the servo sees a 1-cycle additional lag.
- Reset asserted mid-scan: all outputs go to their reset values immediately (asynchronously). Captured bests are lost.

## Structure
- Shared package holds:
  - the state enum;
  - the direction constants DIR_STOP / DIR_CCW / DIR_CW, matching the 2'b00 / 2'b01 / 2'b10 servo encoding;
  - the POS_W = 32 constant.
- One sub-module, peak_tracker: clear / valid / data / position in, best value and best position out. It is instantiated once and shared between axes, cleared on each SWEEP entry.

## Test plan
- Full scan: model positions ramp ±10 per cycle starting at 12000; light peaks at H 15000 and V 9000 → h_best = 15000, v_best = 9000, done pulse, final h_position ≤ 15000.
- Already home (h_position = 4000 at START) → H_HOME lasts 1 cycle, then H_SWEEP with h_btn1 high.
- Ties: two equal peaks, 800 at 11000 and 800 at 18000 → h_best = 11000.
- h_limit asserted at 20000 with POS_MAX = 25000 → sweep ends at 20000, and a light_valid in that same cycle is captured.
- Stalled servo (position frozen) with TIMEOUT_CYC = 100 → timeout_err after 100 cycles in H_HOME, IDLE, all btn low.
- RST asserted mid-V_SWEEP → outputs zero without waiting for a clock edge; ABORT mid-H_RETURN → IDLE next edge, no done pulse.
